// File: rtl/vdp_timing_pkg.sv
// vdp_timing_pkg: shared types, register map and field helper for the VDP raster timing generator.
package vdp_timing_pkg;

    // Region order is cyclic in enum order: FP -> SYNC -> BP -> ACTIVE -> FP.
    typedef enum logic [1:0] {
        ST_FP     = 2'd0,
        ST_SYNC   = 2'd1,
        ST_BP     = 2'd2,
        ST_ACTIVE = 2'd3
    } axis_state_t;

    localparam logic [3:0] ADDR_H_ACTIVE = 4'd0;
    localparam logic [3:0] ADDR_H_FP     = 4'd1;
    localparam logic [3:0] ADDR_H_SYNC   = 4'd2;
    localparam logic [3:0] ADDR_H_BP     = 4'd3;
    localparam logic [3:0] ADDR_V_ACTIVE = 4'd4;
    localparam logic [3:0] ADDR_V_FP     = 4'd5;
    localparam logic [3:0] ADDR_V_SYNC   = 4'd6;
    localparam logic [3:0] ADDR_V_BP     = 4'd7;
    localparam logic [3:0] ADDR_CONTROL  = 4'd8;
    localparam logic [3:0] ADDR_LINE_CMP = 4'd9;

    // One axis worth of region lengths; only the low axis-width bits are meaningful.
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } axis_timing_t;

    // Truncate a written value to the field width; zero becomes one so no region is empty.
    function automatic logic [15:0] fit_field(input logic [15:0] data, input int unsigned width);
        logic [15:0] mask;
        logic [15:0] val;
        mask = 16'((32'd1 << width) - 32'd1);
        val  = data & mask;
        return (val == '0) ? 16'd1 : val;
    endfunction

endpackage

// File: rtl/vdp_timing_axis.sv
// vdp_timing_axis: one raster axis -- position counter plus 4-region FSM.
// ACTIVE_FIRST=0 gives horizontal order (FP first), ACTIVE_FIRST=1 gives vertical order (ACTIVE first).
module vdp_timing_axis
    import vdp_timing_pkg::*;
#(
    parameter int unsigned W            = 11,
    parameter bit          ACTIVE_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  axis_timing_t cfg,
    output logic [W-1:0] pos,
    output axis_state_t  state,
    output axis_state_t  state_next,
    output logic         wrap
);

    localparam axis_state_t FIRST_STATE = ACTIVE_FIRST ? ST_ACTIVE : ST_FP;
    localparam axis_state_t LAST_STATE  = ACTIVE_FIRST ? ST_BP : ST_ACTIVE;
    localparam logic [W:0]   ONE_EXT     = (W+1)'(1);
    localparam logic [W-1:0] ONE         = W'(1);

    logic [W:0]   act_len, fp_len, sync_len, bp_len, base;
    logic [W:0]   end_fp, end_sync, end_bp, end_act, region_end;
    logic [W-1:0] pos_next;

    if (W < 16) begin : g_pad
        logic cfg_unused;
        assign cfg_unused = ^{cfg.active[15:W], cfg.fp[15:W], cfg.sync[15:W], cfg.bp[15:W]};
    end

    assign act_len  = {1'b0, cfg.active[W-1:0]};
    assign fp_len   = {1'b0, cfg.fp[W-1:0]};
    assign sync_len = {1'b0, cfg.sync[W-1:0]};
    assign bp_len   = {1'b0, cfg.bp[W-1:0]};

    // Last position of each region; the blanking regions start after active on the vertical axis.
    assign base     = ACTIVE_FIRST ? act_len : '0;
    assign end_fp   = base + fp_len - ONE_EXT;
    assign end_sync = base + fp_len + sync_len - ONE_EXT;
    assign end_bp   = base + fp_len + sync_len + bp_len - ONE_EXT;
    assign end_act  = ACTIVE_FIRST ? (act_len - ONE_EXT) : (end_bp + act_len);

    assign wrap = en && (state == LAST_STATE) && ({1'b0, pos} == region_end);

    // Next region and position: advance region at its last count, wrap after the final region.
    always_comb begin
        region_end = end_act;
        pos_next   = pos;
        state_next = state;
        case (state)
            ST_FP:   region_end = end_fp;
            ST_SYNC: region_end = end_sync;
            ST_BP:   region_end = end_bp;
            default: region_end = end_act;
        endcase
        if (en) begin
            pos_next = pos + ONE;
            if ({1'b0, pos} == region_end) begin
                case (state)
                    ST_FP:   state_next = ST_SYNC;
                    ST_SYNC: state_next = ST_BP;
                    ST_BP:   state_next = ST_ACTIVE;
                    default: state_next = ST_FP;
                endcase
                if (state == LAST_STATE) begin
                    pos_next = '0;
                end
            end
        end
    end

    // Position and region registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos   <= '0;
            state <= FIRST_STATE;
        end else begin
            pos   <= pos_next;
            state <= state_next;
        end
    end

endmodule

// File: rtl/vdp_video_timing.sv
// vdp_video_timing: runtime-reprogrammable raster timing generator with frame-atomic mode commit.
// Optional line-compare interrupt enabled by defining VDP_TIMING_LINE_IRQ_EN.
module vdp_video_timing
    import vdp_timing_pkg::*;
#(
    parameter int unsigned X_WIDTH   = 11,
    parameter int unsigned Y_WIDTH   = 10,
    parameter int unsigned H_ACTIVE  = 848,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 112,
    parameter int unsigned H_BP      = 112,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 6,
    parameter int unsigned V_SYNC    = 8,
    parameter int unsigned V_BP      = 23,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reg_write,
    input  logic [3:0]         reg_addr,
    input  logic [15:0]        reg_data,
    output logic [X_WIDTH-1:0] raster_x,
    output logic [Y_WIDTH-1:0] raster_y,
    output logic               hsync,
    output logic               vsync,
    output logic               active_display,
    output logic               line_ended,
    output logic               frame_ended,
    output logic               active_line_started,
    output logic               active_frame_ended,
    output logic               mode_pending,
    output logic               line_irq
);

    localparam axis_timing_t H_DEFAULT = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                           sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam axis_timing_t V_DEFAULT = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                           sync: 16'(V_SYNC), bp: 16'(V_BP)};

    axis_timing_t h_stage, v_stage, h_cfg, v_cfg;
    logic         hpol_stage, vpol_stage, hpol_cfg, vpol_cfg, hpol_nx, vpol_nx;
    logic         write_hit, h_wrap, v_wrap, commit;
    axis_state_t  h_state, h_state_next, v_state, v_state_next;

    vdp_timing_axis #(.W(X_WIDTH), .ACTIVE_FIRST(1'b0)) u_h_axis (
        .clk(clk), .reset(reset), .en(1'b1), .cfg(h_cfg), .pos(raster_x),
        .state(h_state), .state_next(h_state_next), .wrap(h_wrap)
    );

    vdp_timing_axis #(.W(Y_WIDTH), .ACTIVE_FIRST(1'b1)) u_v_axis (
        .clk(clk), .reset(reset), .en(h_wrap), .cfg(v_cfg), .pos(raster_y),
        .state(v_state), .state_next(v_state_next), .wrap(v_wrap)
    );

    // The edge that wraps the raster to (0,0) is the commit edge; outputs for (0,0) use the new mode.
    assign commit  = v_wrap;
    assign hpol_nx = commit ? hpol_stage : hpol_cfg;
    assign vpol_nx = commit ? vpol_stage : vpol_cfg;

    // Decode which writes land in a staging register.
    always_comb begin
        write_hit = 1'b0;
        if (reg_write) begin
            case (reg_addr)
                ADDR_H_ACTIVE, ADDR_H_FP, ADDR_H_SYNC, ADDR_H_BP,
                ADDR_V_ACTIVE, ADDR_V_FP, ADDR_V_SYNC, ADDR_V_BP,
                ADDR_CONTROL:  write_hit = 1'b1;
`ifdef VDP_TIMING_LINE_IRQ_EN
                ADDR_LINE_CMP: write_hit = 1'b1;
`endif
                default:       write_hit = 1'b0;
            endcase
        end
    end

    // Staging set and pending flag; a write on the commit edge stays staged for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_stage      <= H_DEFAULT;
            v_stage      <= V_DEFAULT;
            hpol_stage   <= HSYNC_POL;
            vpol_stage   <= VSYNC_POL;
            mode_pending <= 1'b0;
        end else begin
            if (write_hit) begin
                mode_pending <= 1'b1;
            end else if (commit) begin
                mode_pending <= 1'b0;
            end
            if (reg_write) begin
                case (reg_addr)
                    ADDR_H_ACTIVE: h_stage.active <= fit_field(reg_data, X_WIDTH);
                    ADDR_H_FP:     h_stage.fp     <= fit_field(reg_data, X_WIDTH);
                    ADDR_H_SYNC:   h_stage.sync   <= fit_field(reg_data, X_WIDTH);
                    ADDR_H_BP:     h_stage.bp     <= fit_field(reg_data, X_WIDTH);
                    ADDR_V_ACTIVE: v_stage.active <= fit_field(reg_data, Y_WIDTH);
                    ADDR_V_FP:     v_stage.fp     <= fit_field(reg_data, Y_WIDTH);
                    ADDR_V_SYNC:   v_stage.sync   <= fit_field(reg_data, Y_WIDTH);
                    ADDR_V_BP:     v_stage.bp     <= fit_field(reg_data, Y_WIDTH);
                    ADDR_CONTROL: begin
                        hpol_stage <= reg_data[0];
                        vpol_stage <= reg_data[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Committed set, copied from staging at the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cfg    <= H_DEFAULT;
            v_cfg    <= V_DEFAULT;
            hpol_cfg <= HSYNC_POL;
            vpol_cfg <= VSYNC_POL;
        end else if (commit) begin
            h_cfg    <= h_stage;
            v_cfg    <= v_stage;
            hpol_cfg <= hpol_stage;
            vpol_cfg <= vpol_stage;
        end
    end

    // Registered sync, blanking and strobes derived from the next raster position.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync               <= ~HSYNC_POL;
            vsync               <= ~VSYNC_POL;
            active_display      <= 1'b0;
            line_ended          <= 1'b0;
            frame_ended         <= 1'b0;
            active_line_started <= 1'b0;
            active_frame_ended  <= 1'b0;
        end else begin
            hsync               <= (h_state_next == ST_SYNC) ? hpol_nx : ~hpol_nx;
            vsync               <= (v_state_next == ST_SYNC) ? vpol_nx : ~vpol_nx;
            active_display      <= (h_state_next == ST_ACTIVE) && (v_state_next == ST_ACTIVE);
            line_ended          <= h_wrap;
            frame_ended         <= v_wrap;
            active_line_started <= (h_state == ST_BP) && (h_state_next == ST_ACTIVE);
            active_frame_ended  <= (v_state == ST_ACTIVE) && (v_state_next == ST_FP);
        end
    end

`ifdef VDP_TIMING_LINE_IRQ_EN
    logic [Y_WIDTH-1:0] cmp_stage, cmp_cfg, cmp_nx, y_wrapped;

    assign cmp_nx    = commit ? cmp_stage : cmp_cfg;
    assign y_wrapped = v_wrap ? '0 : raster_y + Y_WIDTH'(1);

    // Line-compare staging and committed value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_stage <= '0;
            cmp_cfg   <= '0;
        end else begin
            if (reg_write && (reg_addr == ADDR_LINE_CMP)) begin
                cmp_stage <= reg_data[Y_WIDTH-1:0];
            end
            if (commit) begin
                cmp_cfg <= cmp_stage;
            end
        end
    end

    // Pulse at the start of the compared line.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_irq <= 1'b0;
        end else begin
            line_irq <= h_wrap && (y_wrapped == cmp_nx);
        end
    end
`else
    assign line_irq = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_video_timing.sv
// tb_vdp_video_timing: directed, table-driven check of vdp_video_timing.
`timescale 1ns/1ps
module tb_vdp_video_timing;
    import vdp_timing_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_write = 1'b0;
    logic [3:0]  reg_addr = '0;
    logic [15:0] reg_data = '0;
    logic [10:0] raster_x;
    logic [9:0]  raster_y;
    logic hsync, vsync, active_display, line_ended, frame_ended;
    logic active_line_started, active_frame_ended, mode_pending, line_irq;

    int errors = 0;
    int checks = 0;
    int cur = 0;
    int ht = 1088;
    int vt = 8;
    int irq_seen = 0;

    typedef struct {
        int         f;
        int         x;
        int         y;
        logic [6:0] exp;
    } vec_t;

    vec_t dv[$];
    vec_t sv[$];

    always #5 clk = ~clk;

    // Horizontal defaults as shipped; short vertical default so a whole frame is a few thousand cycles.
    vdp_video_timing #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .reg_addr(reg_addr), .reg_data(reg_data),
        .raster_x(raster_x), .raster_y(raster_y), .hsync(hsync), .vsync(vsync),
        .active_display(active_display), .line_ended(line_ended), .frame_ended(frame_ended),
        .active_line_started(active_line_started), .active_frame_ended(active_frame_ended),
        .mode_pending(mode_pending), .line_irq(line_irq)
    );

    always @(negedge clk) if (line_irq === 1'b1) irq_seen++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int f, input int x, input int y, input logic [6:0] e);
        vec_t v;
        v.f = f; v.x = x; v.y = y; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle index %0d)", name, act, exp, cur);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        cur += n;
    endtask

    task automatic goto(input int f, input int x, input int y);
        int target;
        target = f * ht * vt + y * ht + x;
        if (target < cur) begin
            checks++;
            errors++;
            $display("FAIL goto: target %0d behind current %0d", target, cur);
        end else begin
            step(target - cur);
        end
        chk($sformatf("raster_x f%0d (%0d,%0d)", f, x, y), 32'(raster_x), x);
        chk($sformatf("raster_y f%0d (%0d,%0d)", f, x, y), 32'(raster_y), y);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        reg_write = 1'b1;
        reg_addr  = a;
        reg_data  = d;
        step(1);
        reg_write = 1'b0;
    endtask

    // Caller stands on the last pixel of the frame; step onto the new mode's (0,0).
    task automatic commit_to(input int new_ht, input int new_vt);
        step(1);
        ht  = new_ht;
        vt  = new_vt;
        cur = 0;
        chk("commit raster_x", 32'(raster_x), 0);
        chk("commit raster_y", 32'(raster_y), 0);
        chk("commit frame_ended", 32'(frame_ended), 1);
        chk("commit mode_pending", 32'(mode_pending), 0);
    endtask

    function automatic logic [6:0] outs();
        return {hsync, vsync, active_display, line_ended, frame_ended,
                active_line_started, active_frame_ended};
    endfunction

    initial begin
        int n;
        int lowcnt;

        // bits: hsync vsync active_display line_ended frame_ended active_line_started active_frame_ended
        dv.push_back(mk(0, 1, 0, 7'b1100000));
        dv.push_back(mk(0, 15, 0, 7'b1100000));
        dv.push_back(mk(0, 16, 0, 7'b0100000));
        dv.push_back(mk(0, 127, 0, 7'b0100000));
        dv.push_back(mk(0, 128, 0, 7'b1100000));
        dv.push_back(mk(0, 239, 0, 7'b1100000));
        dv.push_back(mk(0, 240, 0, 7'b1110010));
        dv.push_back(mk(0, 1087, 0, 7'b1110000));
        dv.push_back(mk(0, 0, 1, 7'b1101000));
        dv.push_back(mk(0, 240, 3, 7'b1110010));
        dv.push_back(mk(0, 0, 4, 7'b1101001));
        dv.push_back(mk(0, 240, 4, 7'b1100010));
        dv.push_back(mk(0, 500, 5, 7'b1000000));
        dv.push_back(mk(0, 16, 6, 7'b0000000));
        dv.push_back(mk(0, 0, 7, 7'b1101000));
        dv.push_back(mk(0, 1087, 7, 7'b1100000));
        dv.push_back(mk(1, 0, 0, 7'b1101100));
        dv.push_back(mk(1, 1, 0, 7'b1100000));

        // Small mode H 8/1/2/1 (HO=4, HT=12), V 4/1/1/1 (VT=7).
        sv.push_back(mk(0, 0, 0, 7'b1101100));
        sv.push_back(mk(0, 1, 0, 7'b0100000));
        sv.push_back(mk(0, 2, 0, 7'b0100000));
        sv.push_back(mk(0, 3, 0, 7'b1100000));
        sv.push_back(mk(0, 4, 0, 7'b1110010));
        sv.push_back(mk(0, 11, 0, 7'b1110000));
        sv.push_back(mk(0, 0, 1, 7'b1101000));
        sv.push_back(mk(0, 11, 3, 7'b1110000));
        sv.push_back(mk(0, 0, 4, 7'b1101001));
        sv.push_back(mk(0, 4, 4, 7'b1100010));
        sv.push_back(mk(0, 1, 5, 7'b0000000));
        sv.push_back(mk(0, 5, 5, 7'b1000000));
        sv.push_back(mk(0, 5, 6, 7'b1100000));
        sv.push_back(mk(0, 11, 6, 7'b1100000));
        sv.push_back(mk(1, 0, 0, 7'b1101100));

        // Reset entry state.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cur = 0;
        chk("reset raster_x", 32'(raster_x), 0);
        chk("reset raster_y", 32'(raster_y), 0);
        chk("reset outputs", 32'(outs()), 32'(7'b1100000));
        chk("reset mode_pending", 32'(mode_pending), 0);
        chk("reset line_irq", 32'(line_irq), 0);

        // Default mode vectors.
        foreach (dv[i]) begin
            goto(dv[i].f, dv[i].x, dv[i].y);
            chk($sformatf("dflt outs f%0d (%0d,%0d)", dv[i].f, dv[i].x, dv[i].y),
                32'(outs()), 32'(dv[i].exp));
        end

        // Frame period between frame_ended pulses.
        n = 0;
        do begin step(1); n++; end while (frame_ended !== 1'b1 && n < 20000);
        chk("frame_ended gap to next frame", n, 8703);
        n = 0;
        do begin step(1); n++; end while (frame_ended !== 1'b1 && n < 20000);
        chk("frame_ended period", n, 1088 * 8);

        // Reprogram mid-frame; commit waits for the wrap.
        goto(3, 100, 2);
        wr(ADDR_H_ACTIVE, 16'd8);
        wr(ADDR_H_FP, 16'd1);
        wr(ADDR_H_SYNC, 16'd2);
        wr(ADDR_H_BP, 16'd1);
        wr(ADDR_V_ACTIVE, 16'd4);
        wr(ADDR_V_FP, 16'd1);
        wr(ADDR_V_SYNC, 16'd1);
        wr(ADDR_V_BP, 16'd1);
        chk("pending after writes", 32'(mode_pending), 1);
        goto(3, 1087, 7);
        chk("pending before wrap", 32'(mode_pending), 1);
        commit_to(12, 7);

        foreach (sv[i]) begin
            goto(sv[i].f, sv[i].x, sv[i].y);
            chk($sformatf("small outs f%0d (%0d,%0d)", sv[i].f, sv[i].x, sv[i].y),
                32'(outs()), 32'(sv[i].exp));
        end

        // Write sampled on the commit edge stays staged.
        goto(1, 11, 6);
        chk("pending idle", 32'(mode_pending), 0);
        wr(ADDR_H_ACTIVE, 16'd6);
        chk("commit-edge write raster_x", 32'(raster_x), 0);
        chk("commit-edge write frame_ended", 32'(frame_ended), 1);
        chk("commit-edge write pending", 32'(mode_pending), 1);
        goto(2, 11, 0);
        chk("old mode still active", 32'(active_display), 1);
        goto(2, 11, 6);
        commit_to(10, 7);
        goto(0, 9, 0);
        chk("H_ACTIVE=6 last pixel active", 32'(active_display), 1);
        goto(0, 0, 1);
        chk("H_ACTIVE=6 wrap line_ended", 32'(line_ended), 1);

        // Zero H_SYNC is stored as one.
        wr(ADDR_H_SYNC, 16'd0);
        goto(0, 9, 6);
        commit_to(9, 7);
        lowcnt = 0;
        for (int x = 0; x < 9; x++) begin
            goto(0, x, 1);
            if (hsync === 1'b0) lowcnt++;
        end
        chk("hsync width with H_SYNC=0", lowcnt, 1);
        goto(0, 1, 2);
        chk("hsync x=1", 32'(hsync), 0);
        goto(0, 2, 2);
        chk("hsync x=2", 32'(hsync), 1);

        // Polarity change takes effect only at commit.
        wr(ADDR_CONTROL, 16'd3);
        goto(0, 1, 3);
        chk("hsync pol before commit", 32'(hsync), 0);
        goto(0, 1, 5);
        chk("vsync pol before commit", 32'(vsync), 0);
        goto(0, 8, 6);
        commit_to(9, 7);
        chk("hsync inactive high-pol", 32'(hsync), 0);
        goto(0, 1, 0);
        chk("hsync active high-pol", 32'(hsync), 1);
        chk("vsync inactive high-pol", 32'(vsync), 0);
        goto(0, 1, 5);
        chk("vsync active high-pol", 32'(vsync), 1);

`ifdef VDP_TIMING_LINE_IRQ_EN
        wr(ADDR_LINE_CMP, 16'd2);
        chk("line cmp write pending", 32'(mode_pending), 1);
        goto(0, 8, 6);
        commit_to(9, 7);
        for (int y = 0; y < 7; y++) begin
            for (int x = 0; x < 9; x++) begin
                goto(0, x, y);
                chk($sformatf("line_irq (%0d,%0d)", x, y), 32'(line_irq),
                    32'((x == 0 && y == 2) ? 1 : 0));
            end
        end
`else
        wr(ADDR_LINE_CMP, 16'd2);
        chk("line cmp write ignored", 32'(mode_pending), 0);
        chk("line_irq never asserted", irq_seen, 0);
`endif

        // Reset mid-frame discards the staged write and restores defaults.
        wr(ADDR_H_ACTIVE, 16'd20);
        chk("pending before reset", 32'(mode_pending), 1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ht = 1088;
        vt = 8;
        cur = 0;
        chk("mid reset raster_x", 32'(raster_x), 0);
        chk("mid reset raster_y", 32'(raster_y), 0);
        chk("mid reset outputs", 32'(outs()), 32'(7'b1100000));
        chk("mid reset pending", 32'(mode_pending), 0);
        goto(0, 1, 0);
        chk("after reset outs (1,0)", 32'(outs()), 32'(7'b1100000));
        goto(0, 1087, 0);
        goto(0, 0, 1);
        chk("after reset first line_ended", 32'(outs()), 32'(7'b1101000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
